// File: rtl/serial_tx_engine_pkg.sv
// serial_pkg: shared state type, default widths and beat-count helper
// for the parametrised serial transmitter.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LENGTH     = 4;
    localparam int DEFAULT_DIV        = 4;

    // Number of output beats needed to carry a dw-bit word in len-bit chunks.
    function automatic int beats(input int dw, input int len);
        return dw / len;
    endfunction

endpackage

// File: rtl/serial_tx_engine_baud_tick_gen.sv
// baud_tick_gen: divides the system clock into a one-cycle beat tick every
// DIV clocks while enabled; the count restarts whenever enable drops.
module baud_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    // Free-running 0..DIV-1 counter, held at zero while disabled or in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx_engine.sv
// serial_tx_engine: captures a DATA_WIDTH word and sends it out as
// DATA_WIDTH/LENGTH beats of LENGTH bits, one beat every DIV clocks.
// Optional macro SERIAL_TX_PARITY_EN appends one even-parity beat per frame.
module serial_tx_engine
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LENGTH     = DEFAULT_LENGTH,
    parameter int DIV        = DEFAULT_DIV,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sample,
    input  logic                  startTx,
    output logic                  txBusy,
    output logic                  txDone,
    output logic [LENGTH-1:0]     dout,
    output logic                  dout_valid
);

    localparam int BEATS  = beats(DATA_WIDTH, LENGTH);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [BEAT_W-1:0] PARITY_BEAT = BEAT_W'(BEATS);
`endif

    // Reject configurations that cannot split the word into whole beats.
    generate
        if (LENGTH < 1 || LENGTH > DATA_WIDTH || (DATA_WIDTH % LENGTH) != 0) begin : g_bad_length
            $fatal(1, "serial_tx_engine: DATA_WIDTH must be a multiple of LENGTH");
        end
        if (DIV < 1) begin : g_bad_div
            $fatal(1, "serial_tx_engine: DIV must be at least 1");
        end
    endgenerate

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] mem;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  tick;
    logic                  tick_enable;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_bit;
`endif

    assign tick_enable = (state == SHIFT);

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(tick_enable),
        .tick  (tick)
    );

    // Frame sequencer: capture in IDLE, shift a chunk out on every tick, then a one-cycle DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mem        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            txBusy     <= 1'b0;
            txDone     <= 1'b0;
            beat_cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            dout_valid <= 1'b0;
            txDone     <= 1'b0;
            case (state)
                IDLE: begin
                    txBusy <= 1'b0;
                    if (sample) begin
                        mem <= din;
                    end
                    if (startTx) begin
                        state    <= SHIFT;
                        beat_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        parity_bit <= sample ? ^din : ^mem;
`endif
                    end
                end
                SHIFT: begin
                    txBusy <= 1'b1;
                    if (tick) begin
                        dout_valid <= 1'b1;
                        beat_cnt   <= beat_cnt + BEAT_W'(1);
`ifdef SERIAL_TX_PARITY_EN
                        if (beat_cnt == PARITY_BEAT) begin
                            dout  <= LENGTH'(parity_bit);
                            state <= DONE;
                        end else if (MSB_FIRST != 0) begin
                            dout <= mem[DATA_WIDTH-1 -: LENGTH];
                            mem  <= mem << LENGTH;
                        end else begin
                            dout <= mem[LENGTH-1:0];
                            mem  <= mem >> LENGTH;
                        end
`else
                        if (MSB_FIRST != 0) begin
                            dout <= mem[DATA_WIDTH-1 -: LENGTH];
                            mem  <= mem << LENGTH;
                        end else begin
                            dout <= mem[LENGTH-1:0];
                            mem  <= mem >> LENGTH;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
                    txDone   <= 1'b1;
                    txBusy   <= 1'b0;
                    beat_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
